spi_shift_datapath: RTL
=======================

Name: spi_shift_datapath

Overview:
Serial datapath that sits directly downstream of the SPI control FSM and the input conditioners. It consumes SR_WE, ADDR_WE and BUF_E plus the conditioned SCLK edges and MOSI. It shifts the incoming bits into a parallel register, latches the address/RW byte, loads read data from data memory, and drives MISO. It also provides a bit counter and a byte-complete strobe so the FSM can sequence address and data phases.

Parameters:
WIDTH, 8, shift register / byte width in bits (min 2)
CNT_W, 3, bit counter width; must satisfy 2**CNT_W == WIDTH

Ports:
clk  input  1  system clock; all state updates on posedge clk
reset  input  1  synchronous active-high reset
posedge_sclk  input  1  one-clk pulse from input conditioner on SCLK rising edge
negedge_sclk  input  1  one-clk pulse from input conditioner on SCLK falling edge
cs  input  1  conditioned chip select, active-low
mosi  input  1  conditioned serial data in
SR_WE  input  2  shift reg op from FSM: 00 hold, 01 shift, 10 parallel load, 11 reserved (=hold)
ADDR_WE  input  1  latch address/RW from shift reg
BUF_E  input  1  MISO output enable from FSM
par_in  input  WIDTH  read data from data memory
par_out  output  WIDTH  current shift register contents (write data to memory)
addr  output  WIDTH-1  latched address
rw  output  1  latched RW bit (1 = read)
miso  output  1  serial data out, 0 when not enabled
miso_oe  output  1  tristate enable for pad
bit_cnt  output  CNT_W  bits shifted in current byte
byte_done  output  1  one-clk pulse when WIDTH-th bit of a byte is shifted in

Behaviour:
- Reset (sync, highest priority): par_out=0, addr=0, rw=0, miso_q=0, miso=0, miso_oe=0, bit_cnt=0, byte_done=0.
- cs high (deselected): bit_cnt forced to 0; no shift, even if SR_WE=01; parallel load is still honoured; byte_done=0; miso_oe=0.
- Shift: cs low, SR_WE=01 and posedge_sclk → sr <= {sr[WIDTH-2:0], mosi} (MSB first). bit_cnt <= bit_cnt+1, wrapping WIDTH-1→0.
- byte_done: registered; asserted for exactly one clk in the cycle after the shift that wraps bit_cnt from WIDTH-1 to 0. No second pulse unless WIDTH more edges occur.
- Parallel load: SR_WE=10 → sr <= par_in on that clk, independent of the SCLK edges. bit_cnt is unchanged.
- SR_WE=00/11: sr holds.
- ADDR_WE=1 → addr <= sr[WIDTH-1:1], rw <= sr[0] in the same clk. If ADDR_WE coincides with a shift, the latch takes the pre-shift sr value.
- MISO: on negedge_sclk, miso_q <= sr[WIDTH-1]. After a parallel load, miso_q is also updated to par_in[WIDTH-1] on the load cycle so the first bit is valid before the first falling edge.
  - While BUF_E=1 and cs low, sr also shifts left by one on each negedge_sclk, inserting 0. This presents read data on successive falling edges.
  - Shift on posedge_sclk remains gated by SR_WE=01.
- miso_oe = BUF_E & ~cs (combinational); miso = miso_oe ? miso_q : 0.
- Simultaneous posedge_sclk and negedge_sclk: cannot occur from the conditioner. If both are asserted, posedge action wins and negedge is ignored.
- cs rising mid-byte: bit_cnt clears next clk, partial sr contents are retained, no byte_done.
- Reset mid-transfer: all state clears next clk regardless of cs/SR_WE.
- Latency: par_out reflects a shift one clk after the posedge_sclk pulse; addr/rw one clk after ADDR_WE.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: shift becomes sr <= {mosi, sr[WIDTH-1:1]}. MISO sources sr[0], and read shift-out moves right. Address latch becomes addr <= sr[WIDTH-2:0], rw <= sr[WIDTH-1].
- Undefined: MSB-first behaviour as above.

Test Plan:
- Reset with cs=0, SR_WE=01, SCLK toggling → all outputs 0 throughout reset; bit_cnt stays 0.
- cs=0, SR_WE=01, shift 8'b1010_0111 MSB first → par_out=8'hA7; byte_done pulses once, one clk after the 8th posedge; bit_cnt returns 0.
- After above, ADDR_WE=1 for 1 clk → addr=7'h53, rw=1.
- SR_WE=10 with par_in=8'hC3, then BUF_E=1, cs=0, 8 SCLK falling edges → miso sequence 1,1,0,0,0,0,1,1 and miso_oe=1. Then BUF_E=0 → miso=0, miso_oe=0.
- Shift 5 bits, then raise cs → bit_cnt=0 next clk, no byte_done. Re-select and shift 8 bits → exactly one byte_done.
- SR_WE=01 with cs=1 and SCLK toggling → par_out unchanged, bit_cnt=0. SR_WE=11 with cs=0 → par_out unchanged.

Source files
------------

// File: rtl/spi_shift_datapath_if.sv
// Handshake bundle between the SPI control FSM (master) and the serial shift datapath (slave).
`timescale 1ns/1ps

interface spi_shift_datapath_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             posedge_sclk;
    logic             negedge_sclk;
    logic             cs;
    logic             mosi;
    logic [1:0]       sr_we;
    logic             addr_we;
    logic             buf_e;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] par_out;
    logic [WIDTH-2:0] addr;
    logic             rw;
    logic             miso;
    logic             miso_oe;
    logic [CNT_W-1:0] bit_cnt;
    logic             byte_done;

    modport master (
        output posedge_sclk, negedge_sclk, cs, mosi, sr_we, addr_we, buf_e, par_in,
        input  par_out, addr, rw, miso, miso_oe, bit_cnt, byte_done
    );

    modport slave (
        input  posedge_sclk, negedge_sclk, cs, mosi, sr_we, addr_we, buf_e, par_in,
        output par_out, addr, rw, miso, miso_oe, bit_cnt, byte_done
    );
endinterface

// File: rtl/spi_shift_datapath.sv
// SPI serial datapath: shift-in, address/RW latch, read-data shift-out on MISO, bit counter.
// Define SPI_LSB_FIRST_EN for LSB-first framing; MSB-first when undefined.
`timescale 1ns/1ps

module spi_shift_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    spi_shift_datapath_if.slave   dp_if
);
    localparam logic [1:0] SR_SHIFT = 2'b01;
    localparam logic [1:0] SR_LOAD  = 2'b10;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-2:0] addr_q, addr_d;
    logic             rw_q, rw_d;
    logic             miso_q, miso_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             byte_done_q, byte_done_d;

    logic [WIDTH-1:0] sr_shift_in;
    logic [WIDTH-1:0] sr_shift_out;
    logic [WIDTH-2:0] latch_addr;
    logic             latch_rw;
    logic             out_bit;
    logic             par_in_out_bit;

`ifdef SPI_LSB_FIRST_EN
    assign sr_shift_in    = {dp_if.mosi, sr_q[WIDTH-1:1]};
    assign sr_shift_out   = {1'b0, sr_q[WIDTH-1:1]};
    assign latch_addr     = sr_q[WIDTH-2:0];
    assign latch_rw       = sr_q[WIDTH-1];
    assign out_bit        = sr_q[0];
    assign par_in_out_bit = dp_if.par_in[0];
`else
    assign sr_shift_in    = {sr_q[WIDTH-2:0], dp_if.mosi};
    assign sr_shift_out   = {sr_q[WIDTH-2:0], 1'b0};
    assign latch_addr     = sr_q[WIDTH-1:1];
    assign latch_rw       = sr_q[0];
    assign out_bit        = sr_q[WIDTH-1];
    assign par_in_out_bit = dp_if.par_in[WIDTH-1];
`endif

    logic do_shift_in;
    logic do_fall;
    logic do_shift_out;
    logic do_load;

    // A coincident rising edge masks the falling edge entirely.
    assign do_shift_in  = ~dp_if.cs & (dp_if.sr_we == SR_SHIFT) & dp_if.posedge_sclk;
    assign do_fall      = dp_if.negedge_sclk & ~dp_if.posedge_sclk;
    assign do_shift_out = do_fall & dp_if.buf_e & ~dp_if.cs;
    assign do_load      = (dp_if.sr_we == SR_LOAD);

    always_comb begin
        sr_d        = sr_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        miso_d      = miso_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = 1'b0;

        if (do_load) begin
            sr_d   = dp_if.par_in;
            miso_d = par_in_out_bit;
        end else begin
            if (do_fall)
                miso_d = out_bit;
            if (do_shift_in)
                sr_d = sr_shift_in;
            else if (do_shift_out)
                sr_d = sr_shift_out;
        end

        if (dp_if.cs) begin
            bit_cnt_d = '0;
        end else if (do_shift_in) begin
            bit_cnt_d   = bit_cnt_q + 1'b1;
            byte_done_d = (bit_cnt_q == CNT_W'(WIDTH - 1));
        end

        if (dp_if.addr_we) begin
            addr_d = latch_addr;
            rw_d   = latch_rw;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q        <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            miso_q      <= 1'b0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            miso_q      <= miso_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
        end
    end

    // Pad enable is held off while reset is asserted.
    assign dp_if.miso_oe   = dp_if.buf_e & ~dp_if.cs & ~reset_i;
    assign dp_if.miso      = dp_if.miso_oe ? miso_q : 1'b0;
    assign dp_if.par_out   = sr_q;
    assign dp_if.addr      = addr_q;
    assign dp_if.rw        = rw_q;
    assign dp_if.bit_cnt   = bit_cnt_q;
    assign dp_if.byte_done = byte_done_q;

endmodule
